// File: rtl/seq_shifter_pkg.sv
// seq_shifter_pkg: shared types and helpers for the handshaked iterative shifter.
package seq_shifter_pkg;
  typedef enum logic [1:0] {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL} shift_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
  // Shifts clamp at width; rotates wrap. ovf flags amounts beyond the width.
  function automatic int unsigned calc_count(input int unsigned amt, input int unsigned width,
                                             input shift_op_e op, output logic ovf);
    ovf = amt > width;
    return op == SHIFT_ROL ? amt % width : (ovf ? width : amt);
  endfunction
  // An over-range shift ends with carry 0, or the sign for SRA; rotates are unaffected.
  function automatic logic final_carry(input logic ovf, input shift_op_e op, input logic c, input logic msb);
    return (!ovf || op == SHIFT_ROL) ? c : (op == SHIFT_SRA) && msb;
  endfunction
endpackage

// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/result handshake bundle between operand source and writeback.
interface seq_shifter_if #(parameter int WIDTH = 8);
  import seq_shifter_pkg::*;
  localparam int AMT_W = $clog2(WIDTH) + 1;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  shift_op_e in_op;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic out_carry;
  logic out_zero;
  logic busy;
  modport master(output in_valid, in_data, in_amt, in_op, out_ready,
                 input in_ready, out_valid, out_data, out_carry, out_zero, busy);
  modport slave(input in_valid, in_data, in_amt, in_op, out_ready,
                output in_ready, out_valid, out_data, out_carry, out_zero, busy);
endinterface

// File: rtl/seq_shifter_step.sv
// shift_step: combinational shift/rotate by STEP bits, carry is the last bit moved out.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP = 1
) (
  input  logic [WIDTH-1:0] data,
  input  shift_op_e        op,
  output logic [WIDTH-1:0] next_data,
  output logic             carry
);
  logic [WIDTH:0] sl, sr, sa;
  logic [WIDTH-1:0] rl;
  // One spare bit on the exit side captures the carry for every op.
  assign sl = {1'b0, data} << STEP;
  assign sr = {data, 1'b0} >> STEP;
  assign sa = $signed({data, 1'b0}) >>> STEP;
  assign rl = (data << STEP) | (data >> (WIDTH - STEP));
  always_comb begin
    next_data = op == SHIFT_SLL ? sl[WIDTH-1:0] : op == SHIFT_SRL ? sr[WIDTH:1] : op == SHIFT_SRA ? sa[WIDTH:1] : rl;
    carry = op == SHIFT_SLL ? sl[WIDTH] : op == SHIFT_SRL ? sr[0] : op == SHIFT_SRA ? sa[0] : rl[0];
  end
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: handshaked SLL/SRL/SRA/ROL shifter with carry and zero flags, one bit per clock.
// Define SEQ_SHIFTER_FAST_EN to replace the iteration with a single-cycle barrel shifter.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  seq_shifter_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH) + 1;
  state_e state;
  logic [WIDTH-1:0] data;
  logic carry, zero, req_ovf;
  logic [AMT_W-1:0] req_count;
  assign bus.in_ready  = state == ST_IDLE;
  assign bus.out_valid = state == ST_DONE;
  assign bus.busy      = state != ST_IDLE;
  assign bus.out_data  = data;
  assign bus.out_carry = carry;
  assign bus.out_zero  = zero;
  always_comb begin
    req_ovf = 1'b0;
    req_count = AMT_W'(calc_count(32'(bus.in_amt), WIDTH, bus.in_op, req_ovf));
  end
`ifdef SEQ_SHIFTER_FAST_EN
  localparam int L = $clog2(WIDTH);
  logic [WIDTH-1:0] bd [L+2];
  logic bc [L+2];
  logic [WIDTH-1:0] sd [L+1];
  logic sc [L+1];
  assign bd[0] = bus.in_data;
  assign bc[0] = 1'b0;
  // Stage k moves 2**k bits; the last enabled stage supplies the overall carry.
  for (genvar k = 0; k <= L; k++) begin : g_stage
    shift_step #(.WIDTH(WIDTH), .STEP(1 << k)) u_step (
      .data(bd[k]), .op(bus.in_op), .next_data(sd[k]), .carry(sc[k]));
    assign bd[k+1] = req_count[k] ? sd[k] : bd[k];
    assign bc[k+1] = req_count[k] ? sc[k] : bc[k];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      data  <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (bus.in_valid) begin
        data  <= bd[L+1];
        carry <= final_carry(req_ovf, bus.in_op, bc[L+1], bd[L+1][WIDTH-1]);
        zero  <= bd[L+1] == '0;
        state <= ST_DONE;
      end
    end else if (bus.out_ready) state <= ST_IDLE;
  end
`else
  shift_op_e op;
  logic [AMT_W-1:0] count;
  logic ovf, step_carry;
  logic [WIDTH-1:0] step_data;
  shift_step #(.WIDTH(WIDTH), .STEP(1)) u_step (
    .data(data), .op(op), .next_data(step_data), .carry(step_carry));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      data  <= '0;
      count <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
      op    <= SHIFT_SLL;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          data  <= bus.in_data;
          op    <= bus.in_op;
          count <= req_count;
          ovf   <= req_ovf;
          carry <= 1'b0;
          zero  <= bus.in_data == '0;
          state <= req_count == '0 ? ST_DONE : ST_SHIFT;
        end
        ST_SHIFT: begin
          data  <= step_data;
          count <= count - AMT_W'(1);
          carry <= count == AMT_W'(1) ? final_carry(ovf, op, step_carry, step_data[WIDTH-1]) : step_carry;
          zero  <= step_data == '0;
          state <= count == AMT_W'(1) ? ST_DONE : ST_SHIFT;
        end
        default: if (bus.out_ready) state <= ST_IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed and random checks of seq_shifter (WIDTH 4 and 8) against an arithmetic model.
module tb_seq_shifter;
  import seq_shifter_pkg::*;
`ifdef SEQ_SHIFTER_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, checks = 0, errors = 0, last_acc = 0, last_lat = 0;
  seq_shifter_if #(.WIDTH(4)) if4 ();
  seq_shifter_if #(.WIDTH(8)) if8 ();
  seq_shifter #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  seq_shifter #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int w; longint d; int amt; int op; longint r; bit c; int lat;} vec_t;
  vec_t vecs [8] = '{
    '{4, 'hD, 2, 0, 'h4, 1'b1, 3}, '{4, 'hD, 2, 1, 'h3, 1'b0, 3},
    '{4, 'hD, 2, 2, 'hF, 1'b0, 3}, '{4, 'hD, 1, 3, 'hB, 1'b1, 2},
    '{8, 'h80, 9, 2, 'hFF, 1'b1, 9}, '{8, 'hFF, 9, 1, 'h00, 1'b0, 9},
    '{8, 'h81, 9, 3, 'h03, 1'b1, 2}, '{8, 'hA5, 0, 0, 'hA5, 1'b0, 1}};

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ov(int w); return w == 4 ? if4.out_valid : if8.out_valid; endfunction
  function automatic logic ir(int w); return w == 4 ? if4.in_ready : if8.in_ready; endfunction
  function automatic logic bz(int w); return w == 4 ? if4.busy : if8.busy; endfunction
  function automatic logic oc(int w); return w == 4 ? if4.out_carry : if8.out_carry; endfunction
  function automatic logic oz(int w); return w == 4 ? if4.out_zero : if8.out_zero; endfunction
  function automatic longint od(int w); return w == 4 ? longint'(if4.out_data) : longint'(if8.out_data); endfunction

  task automatic drive(input int w, input logic v, input longint d, input int amt, input int op);
    if (w == 4) begin
      if4.in_valid = v; if4.in_data = 4'(d); if4.in_amt = 3'(amt); if4.in_op = shift_op_e'(op);
    end else begin
      if8.in_valid = v; if8.in_data = 8'(d); if8.in_amt = 4'(amt); if8.in_op = shift_op_e'(op);
    end
  endtask

  task automatic set_ready(input int w, input logic r);
    if (w == 4) if4.out_ready = r; else if8.out_ready = r;
  endtask

  // Result = operand moved n places; carry = the last operand bit that crossed the edge.
  function automatic void model(input int w, input longint d, input int amt, input int op,
                                output longint r, output bit c, output int lat);
    longint mask, sx;
    int n;
    mask = (longint'(1) << w) - 1;
    sx = ((d >> (w - 1)) & 1) != 0 ? (d | ~mask) : d;
    n = op == 3 ? amt % w : (amt > w ? w : amt);
    lat = FAST ? 1 : n + 1;
    case (op)
      0: begin r = (d << n) & mask; c = (amt > w || n == 0) ? 1'b0 : ((d >> (w - n)) & 1) != 0; end
      1: begin r = (d >> n) & mask; c = (amt > w || n == 0) ? 1'b0 : ((d >> (n - 1)) & 1) != 0; end
      2: begin r = (sx >>> n) & mask; c = n == 0 ? 1'b0 : ((sx >>> (n - 1)) & 1) != 0; end
      default: begin r = ((d << n) | (d >> (w - n))) & mask; c = n != 0 && (r & 1) != 0; end
    endcase
  endfunction

  task automatic run_op(input int w, input longint d, input int amt, input int op, input int hold,
                        input longint er, input bit ec, input int elat, input bit chain, input string tag);
    int lat;
    longint held;
    for (int i = 0; i < 20 && !ir(w); i++) begin @(posedge clk); #1; end
    check({tag, " in_ready"}, ir(w), 1);
    set_ready(w, hold == 0);
    drive(w, 1'b1, d, amt, op);
    @(posedge clk); #1;
    if (chain) check({tag, " spacing"}, cyc - last_acc, last_lat + 1);
    last_acc = cyc;
    drive(w, 1'b1, $urandom, $urandom_range(0, 15), $urandom_range(0, 3));
    lat = 1;
    while (!ov(w) && lat < 40) begin @(posedge clk); #1; lat++; end
    check({tag, " latency"}, lat, elat);
    check({tag, " data"}, od(w), er);
    check({tag, " carry"}, oc(w), ec);
    check({tag, " zero"}, oz(w), er == 0);
    held = od(w);
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, ov(w), 1);
      check({tag, " hold data"}, od(w), held);
      check({tag, " hold in_ready"}, ir(w), 0);
    end
    drive(w, 1'b0, 0, 0, 0);
    set_ready(w, 1'b1);
    @(posedge clk); #1;
    check({tag, " release valid"}, ov(w), 0);
    check({tag, " bubble ready"}, ir(w), 1);
    last_lat = elat;
  endtask

  initial begin
    longint r;
    bit c;
    int lat, d, amt, op;
    drive(4, 1'b0, 0, 0, 0);
    drive(8, 1'b0, 0, 0, 0);
    set_ready(4, 1'b0);
    set_ready(8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int w = 4; w <= 8; w += 4) begin
      check("reset valid", ov(w), 0);
      check("reset ready", ir(w), 1);
      check("reset busy", bz(w), 0);
      check("reset data", od(w), 0);
      check("reset carry", oc(w), 0);
      check("reset zero", oz(w), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].w, vecs[i].d, vecs[i].amt, vecs[i].op, i == 7 ? 5 : 0, vecs[i].r, vecs[i].c,
             FAST ? 1 : vecs[i].lat, 1'b0, $sformatf("vec%0d", i));
    // Reset in the middle of a 7-step SLL.
    set_ready(8, 1'b0);
    drive(8, 1'b1, 'h01, 7, 0);
    @(posedge clk); #1;
    drive(8, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst valid", ov(8), 0);
    check("midrst busy", bz(8), 0);
    check("midrst data", od(8), 0);
    check("midrst ready", ir(8), 1);
    @(negedge clk) rst_n = 1'b1;
    run_op(8, 'h01, 7, 0, 0, 'h80, 1'b0, FAST ? 1 : 8, 1'b0, "post reset");
    for (int i = 0; i < 500; i++) begin
      d = $urandom_range(0, 255);
      amt = $urandom_range(0, 15);
      op = $urandom_range(0, 3);
      model(8, d, amt, op, r, c, lat);
      run_op(8, d, amt, op, 0, r, c, lat, i > 0, $sformatf("rnd8 %0d op%0d d%0h a%0d", i, op, d, amt));
    end
    for (int i = 0; i < 100; i++) begin
      d = $urandom_range(0, 15);
      amt = $urandom_range(0, 7);
      op = $urandom_range(0, 3);
      model(4, d, amt, op, r, c, lat);
      run_op(4, d, amt, op, 0, r, c, lat, i > 0, $sformatf("rnd4 %0d op%0d d%0h a%0d", i, op, d, amt));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised, handshaked shifter; successor to the 4-bit combinational left/right shifter.
- Supports four ops: logical left, logical right, arithmetic right, rotate left.
- Reports carry-out and zero flags.
- Iterative, one bit per clock; sits between operand registers and the writeback/result path of the BinaryLogic datapath.

Parameters:
- WIDTH, 8, data width; power of two, >= 4.
- AMT_W, $clog2(WIDTH)+1, shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift amount, unsigned.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_carry  out  1  last bit shifted or rotated out.
- out_zero  out  1  out_data == 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state, including mid-shift):
  - state=IDLE; data reg, count, carry = 0.
  - out_valid=0, out_data=0, out_carry=0, out_zero=0, busy=0, in_ready=1.
  - An in-flight operation is discarded.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). Accept when in_valid && in_ready.
- On accept: latch data and op; compute count and the overflow flag ovf = (in_amt > WIDTH).
  - SLL/SRL/SRA: count = min(in_amt, WIDTH).
  - ROL: count = in_amt mod WIDTH (low bits).
  - Next state is DONE if count==0, otherwise SHIFT.
- SHIFT, each cycle: shift data by one, carry <= bit shifted out, count--. When count reaches 0, go to DONE.
  - SLL: zero into bit 0; carry = old MSB.
  - SRL: zero into MSB; carry = old bit 0.
  - SRA: sign replicated into MSB; carry = old bit 0.
  - ROL: old MSB into bit 0; carry = old MSB.
- Overflow (ovf=1): at the transition to DONE, SLL/SRL force carry=0; SRA forces carry=sign. Data is already correct from the clamped count.
- Amount 0: result = operand, carry=0, out_zero evaluated.
- Latency: out_valid asserts count+1 cycles after the accept cycle (cycle 1 when count==0). Max WIDTH+1.
- DONE:
  - out_valid=1. out_data, out_carry, out_zero stay stable until out_ready.
  - When out_valid && out_ready: go to IDLE and drop out_valid.
  - in_ready returns the following cycle, so there is one bubble between ops.
- Inputs are ignored when in_ready=0. out_ready is ignored outside DONE.
- out_data holds the last result in IDLE; it is reloaded only on the next accept.

Optional Feature:
- Macro: SEQ_SHIFTER_FAST_EN.
- Defined:
  - SHIFT state and counter are removed.
  - A combinational log2 barrel shifter computes the result at accept time and registers it.
  - Always DONE at cycle 1 regardless of amount.
  - Results and flags must be bit-identical to the iterative build.
- Undefined: the iterative behaviour above.

Decomposition:
- Package seq_shifter_pkg:
  - op enum (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL).
  - FSM state enum (ST_IDLE, ST_SHIFT, ST_DONE).
  - Function for the count/ovf computation.
- Sub-module shift_step: combinational single-bit step; inputs data and op, outputs next data and carry.
  - Reused in FAST mode as the stage primitive of the barrel.

Test Plan:
- WIDTH=4, data=1101, amt=2, SLL: out_data=0100, carry=1, zero=0. out_valid in cycle 3 after accept.
- WIDTH=4, data=1101, amt=2:
  - SRL: out_data=0011, carry=0.
  - SRA: out_data=1111, carry=0.
  - ROL amt=1: out_data=1011, carry=1.
- WIDTH=8, overflow amounts:
  - SRA 0x80 amt=9 → 0xFF, carry=1.
  - SRL 0xFF amt=9 → 0x00, carry=0, zero=1.
  - ROL 0x81 amt=9 → 0x03, carry=1, latency 2.
- amt=0, SLL 0xA5 → 0xA5, carry=0, out_valid in cycle 1. Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, new in_valid ignored.
- Assert rst_n low mid-SHIFT (SLL 0x01 amt=7, reset at cycle 3):
  - Immediately out_valid=0, busy=0, out_data=0.
  - After release, a new op completes correctly.
- Back-to-back with out_ready=1 and in_valid held high: ops accepted every count+2 cycles; results match a reference model over 500 random ops.
- Repeat the random test with SEQ_SHIFTER_FAST_EN: identical results, all latencies 1.
